execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/exe_pkg.sv | 27 ++
 rtl/execute_stage_mul_seq.sv | 65 ++++++
 rtl/execute_stage.sv | 191 +++++++++++++++++++
 tb/tb_execute_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// exe_pkg: shared constants for the execute stage.
//   DW / RW_W     : default datapath and register-address widths
//   OP_*          : 5-bit opcode encodings
//   ST_*          : multiply FSM state encoding
package exe_pkg;

  localparam int DW   = 8;
  localparam int RW_W = 5;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_NOT = 5'b00101;
  localparam logic [4:0] OP_SLL = 5'b00110;
  localparam logic [4:0] OP_SRL = 5'b00111;
  localparam logic [4:0] OP_MOV = 5'b01000;
  localparam logic [4:0] OP_LD  = 5'b01001;
  localparam logic [4:0] OP_ST  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01011;
  localparam logic [4:0] OP_NOP = 5'b11111;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

endpackage

// File: rtl/execute_stage_mul_seq.sv
// mul_seq: sequential shift-add multiplier, one partial product per cycle.
//   clk, reset : clock, synchronous active-high reset (aborts a multiply)
//   start      : load operands a, b and begin
//   count      : index of the iteration performed in the current cycle
//   done       : high in the cycle performing the last iteration
//   product    : full-width product; valid while done is high
module mul_seq #(
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DW-1:0]          a,
  input  logic [DW-1:0]          b,
  output logic [$clog2(DW)-1:0]  count,
  output logic                   done,
  output logic [2*DW-1:0]        product
);

  localparam int CW = $clog2(DW);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [2*DW-1:0]   mcand_q;
  logic [DW-1:0]     mplier_q;
  logic [2*DW-1:0]   acc_q;
  logic [2*DW-1:0]   acc_next;

  // The last partial product is folded in combinationally so the result
  // is available in the same cycle that done is asserted.
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done     = busy_q && (cnt_q == CW'(DW - 1));
  assign product  = acc_next;
  assign count    = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand_q  <= {{DW{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU stage with EX/MEM forwarding, load-use stall and a
// multi-cycle sequential multiply.
//   clk, reset                     : clock, synchronous active-high reset
//   valid_dec, op_dec              : instruction slot and opcode from decode
//   A_dec, B_dec, imm_dec          : operands and immediate
//   RA_dec, RB_dec, RW_dec         : source / destination register numbers
//   imm_sel_dec                    : immediate replaces operand B in the ALU
//   mux_ans_dm, RW_dm              : memory-stage result for forwarding
//   ans_ex, B_Bypass, RW_ex        : registered result, store data, dest
//   mem_en_ex/mem_rw_ex/mem_mux_sel_ex : registered memory controls
//   flag_z, flag_c                 : registered zero / carry-borrow
//   stall_ex                       : combinational; decode holds while high
module execute_stage #(
  parameter int DW   = 8,
  parameter int RW_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_dec,
  input  logic [4:0]      op_dec,
  input  logic [DW-1:0]   A_dec,
  input  logic [DW-1:0]   B_dec,
  input  logic [DW-1:0]   imm_dec,
  input  logic [RW_W-1:0] RA_dec,
  input  logic [RW_W-1:0] RB_dec,
  input  logic [RW_W-1:0] RW_dec,
  input  logic            imm_sel_dec,
  input  logic [DW-1:0]   mux_ans_dm,
  input  logic [RW_W-1:0] RW_dm,
  output logic [DW-1:0]   ans_ex,
  output logic [DW-1:0]   B_Bypass,
  output logic [RW_W-1:0] RW_ex,
  output logic            mem_en_ex,
  output logic            mem_rw_ex,
  output logic            mem_mux_sel_ex,
  output logic            flag_z,
  output logic            flag_c,
  output logic            stall_ex
);

  import exe_pkg::*;

  localparam int CW = $clog2(DW);

  logic [0:0]       state_q;
  logic [CW-1:0]    mul_count;
  logic             mul_done;
  logic [2*DW-1:0]  mul_product;
  logic             mul_start;

  logic [DW-1:0]    fwd_a;
  logic [DW-1:0]    fwd_b;
  logic [DW-1:0]    alu_b;
  logic             load_use;
  logic             is_mul;
  logic             accept;

  logic             alu_ok;
  logic [DW-1:0]    alu_res;
  logic             alu_c;
  logic             alu_upd_flags;
  logic             alu_mem_en;
  logic             alu_mem_rw;
  logic             alu_mem_sel;
  logic [RW_W-1:0]  alu_rw;

  // A loaded value in EX is not yet available, so EX forwarding is skipped
  // for loads; that case is covered by the load-use stall instead.
  always_comb begin
    fwd_a = A_dec;
    if (RA_dec == RW_ex && RW_ex != '0 && !mem_mux_sel_ex) fwd_a = ans_ex;
    else if (RA_dec == RW_dm && RW_dm != '0)               fwd_a = mux_ans_dm;

    fwd_b = B_dec;
    if (RB_dec == RW_ex && RW_ex != '0 && !mem_mux_sel_ex) fwd_b = ans_ex;
    else if (RB_dec == RW_dm && RW_dm != '0)               fwd_b = mux_ans_dm;
  end

  assign alu_b    = imm_sel_dec ? imm_dec : fwd_b;
  assign load_use = valid_dec && mem_mux_sel_ex && (RW_ex != '0) &&
                    ((RA_dec == RW_ex) || (!imm_sel_dec && (RB_dec == RW_ex)));
  assign is_mul   = valid_dec && (op_dec == OP_MUL);

  // Load-use is resolved before a multiply may start.
  assign mul_start = !reset && (state_q == ST_IDLE) && is_mul && !load_use;
  assign accept    = (state_q == ST_IDLE) && valid_dec && !load_use && !is_mul;

  // Stall drops in the final multiply iteration so decode advances exactly
  // at the edge that writes the product.
  always_comb begin
    stall_ex = 1'b0;
    if (!reset) begin
      if (state_q == ST_IDLE) stall_ex = load_use || is_mul;
      else                    stall_ex = (mul_count != CW'(DW - 1));
    end
  end

  always_comb begin
    alu_ok        = 1'b1;
    alu_res       = '0;
    alu_c         = 1'b0;
    alu_upd_flags = 1'b1;
    alu_mem_en    = 1'b0;
    alu_mem_rw    = 1'b0;
    alu_mem_sel   = 1'b0;
    alu_rw        = RW_dec;
    case (op_dec)
      OP_ADD: {alu_c, alu_res} = {1'b0, fwd_a} + {1'b0, alu_b};
      // Bit DW of the widened difference is the borrow.
      OP_SUB: {alu_c, alu_res} = {1'b0, fwd_a} - {1'b0, alu_b};
      OP_AND: alu_res = fwd_a & alu_b;
      OP_OR:  alu_res = fwd_a | alu_b;
      OP_XOR: alu_res = fwd_a ^ alu_b;
      OP_NOT: alu_res = ~fwd_a;
      OP_SLL: alu_res = fwd_a << alu_b[2:0];
      OP_SRL: alu_res = fwd_a >> alu_b[2:0];
      OP_MOV: alu_res = alu_b;
      OP_LD: begin
        alu_res       = fwd_a + imm_dec;
        alu_upd_flags = 1'b0;
        alu_mem_en    = 1'b1;
        alu_mem_sel   = 1'b1;
      end
      OP_ST: begin
        alu_res       = fwd_a + imm_dec;
        alu_upd_flags = 1'b0;
        alu_mem_en    = 1'b1;
        alu_mem_rw    = 1'b1;
        alu_rw        = '0;
      end
      default: alu_ok = 1'b0;
    endcase
  end

  mul_seq #(.DW(DW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (fwd_a),
    .b       (fwd_b),
    .count   (mul_count),
    .done    (mul_done),
    .product (mul_product)
  );

  // ---- decode -> execute register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ans_ex         <= '0;
      B_Bypass       <= '0;
      RW_ex          <= '0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b0;
      flag_z         <= 1'b0;
      flag_c         <= 1'b0;
    end else begin
      // Bubble by default; flags hold.
      ans_ex         <= '0;
      B_Bypass       <= '0;
      RW_ex          <= '0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b0;
      if (state_q == ST_MUL_BUSY) begin
        if (mul_done) begin
          state_q <= ST_IDLE;
          ans_ex  <= mul_product[DW-1:0];
          RW_ex   <= RW_dec;
          flag_z  <= (mul_product[DW-1:0] == '0);
          flag_c  <= |mul_product[2*DW-1:DW];
        end
      end else if (mul_start) begin
        state_q <= ST_MUL_BUSY;
      end else if (accept && alu_ok) begin
        ans_ex         <= alu_res;
        B_Bypass       <= fwd_b;
        RW_ex          <= alu_rw;
        mem_en_ex      <= alu_mem_en;
        mem_rw_ex      <= alu_mem_rw;
        mem_mux_sel_ex <= alu_mem_sel;
        if (alu_upd_flags) begin
          flag_z <= (alu_res == '0);
          flag_c <= alu_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_dec;
  logic [4:0] op_dec;
  logic [7:0] A_dec, B_dec, imm_dec;
  logic [4:0] RA_dec, RB_dec, RW_dec;
  logic       imm_sel_dec;
  logic [7:0] mux_ans_dm;
  logic [4:0] RW_dm;
  logic [7:0] ans_ex, B_Bypass;
  logic [4:0] RW_ex;
  logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
  logic       flag_z, flag_c, stall_ex;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage #(.DW(8), .RW_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_dec      (valid_dec),
    .op_dec         (op_dec),
    .A_dec          (A_dec),
    .B_dec          (B_dec),
    .imm_dec        (imm_dec),
    .RA_dec         (RA_dec),
    .RB_dec         (RB_dec),
    .RW_dec         (RW_dec),
    .imm_sel_dec    (imm_sel_dec),
    .mux_ans_dm     (mux_ans_dm),
    .RW_dm          (RW_dm),
    .ans_ex         (ans_ex),
    .B_Bypass       (B_Bypass),
    .RW_ex          (RW_ex),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_mux_sel_ex (mem_mux_sel_ex),
    .flag_z         (flag_z),
    .flag_c         (flag_c),
    .stall_ex       (stall_ex)
  );

  typedef struct {
    logic       valid;
    logic [4:0] op;
    logic [7:0] a, b, imm;
    logic       isel;
    logic [4:0] rw;
    logic [7:0] e_ans, e_bb;
    logic [4:0] e_rw;
    logic [2:0] e_mem;  // {en, rw, mux_sel}
    logic       e_z, e_c;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] ans, input logic [7:0] bb,
                         input logic [4:0] rw, input logic [2:0] mem,
                         input logic z, input logic c);
    chk({nm, ".ans_ex"},   16'(ans_ex),   16'(ans));
    chk({nm, ".B_Bypass"}, 16'(B_Bypass), 16'(bb));
    chk({nm, ".RW_ex"},    16'(RW_ex),    16'(rw));
    chk({nm, ".mem"},      16'({mem_en_ex, mem_rw_ex, mem_mux_sel_ex}), 16'(mem));
    chk({nm, ".flag_z"},   16'(flag_z),   16'(z));
    chk({nm, ".flag_c"},   16'(flag_c),   16'(c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] op, input logic [7:0] a, b, imm,
                       input logic isel, input logic [4:0] ra, rb, rw);
    valid_dec = v; op_dec = op; A_dec = a; B_dec = b; imm_dec = imm;
    imm_sel_dec = isel; RA_dec = ra; RB_dec = rb; RW_dec = rw;
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'b00000, 8'hF0, 8'h20, 8'h00, 1'b0, 5'd3,  8'h10, 8'h20, 5'd3,  3'b000, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 5'b00001, 8'h05, 8'h07, 8'h00, 1'b0, 5'd4,  8'hFE, 8'h07, 5'd4,  3'b000, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 5'b00001, 8'h07, 8'h07, 8'h00, 1'b0, 5'd5,  8'h00, 8'h07, 5'd5,  3'b000, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 5'b00010, 8'hF0, 8'h3C, 8'h00, 1'b0, 5'd6,  8'h30, 8'h3C, 5'd6,  3'b000, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 5'b00011, 8'h0F, 8'hF0, 8'h00, 1'b0, 5'd7,  8'hFF, 8'hF0, 5'd7,  3'b000, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 5'b00100, 8'hAA, 8'hAA, 8'h00, 1'b0, 5'd8,  8'h00, 8'hAA, 5'd8,  3'b000, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 5'b00101, 8'hFF, 8'h00, 8'h00, 1'b0, 5'd9,  8'h00, 8'h00, 5'd9,  3'b000, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 5'b00110, 8'h81, 8'h0B, 8'h00, 1'b0, 5'd10, 8'h08, 8'h0B, 5'd10, 3'b000, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 5'b00111, 8'h80, 8'h07, 8'h00, 1'b0, 5'd11, 8'h01, 8'h07, 5'd11, 3'b000, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 5'b00000, 8'h10, 8'h33, 8'hF0, 1'b1, 5'd12, 8'h00, 8'h33, 5'd12, 3'b000, 1'b1, 1'b1};
    vt[10] = '{1'b1, 5'b01001, 8'h10, 8'h44, 8'h05, 1'b1, 5'd13, 8'h15, 8'h44, 5'd13, 3'b101, 1'b1, 1'b1};
    vt[11] = '{1'b1, 5'b01000, 8'h00, 8'h77, 8'h5A, 1'b1, 5'd14, 8'h5A, 8'h77, 5'd14, 3'b000, 1'b0, 1'b0};
    vt[12] = '{1'b1, 5'b11111, 8'h12, 8'h34, 8'h00, 1'b0, 5'd15, 8'h00, 8'h00, 5'd0,  3'b000, 1'b0, 1'b0};
    vt[13] = '{1'b1, 5'b00001, 8'h00, 8'h01, 8'h00, 1'b0, 5'd16, 8'hFF, 8'h01, 5'd16, 3'b000, 1'b0, 1'b1};
    vt[14] = '{1'b0, 5'b00000, 8'h12, 8'h34, 8'h00, 1'b0, 5'd17, 8'h00, 8'h00, 5'd0,  3'b000, 1'b0, 1'b1};
    vt[15] = '{1'b1, 5'b01100, 8'h12, 8'h34, 8'h00, 1'b0, 5'd18, 8'h00, 8'h00, 5'd0,  3'b000, 1'b0, 1'b1};

    // Reset with a MUL sitting in decode: stall must stay low.
    reset = 1'b1;
    mux_ans_dm = 8'h00; RW_dm = 5'd0;
    issue(1'b1, 5'b01011, 8'h03, 8'h04, 8'h00, 1'b0, 5'd8, 5'd9, 5'd5);
    step();
    step();
    chk("reset.stall", 16'(stall_ex), 16'd0);
    chk_all("reset", 8'h00, 8'h00, 5'd0, 3'b000, 1'b0, 1'b0);
    reset = 1'b0;
    issue(1'b0, 5'b11111, 8'h00, 8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 5'd0);
    step();

    // Single-cycle operations, no forwarding (sources R1/R2 never produced).
    for (int i = 0; i < 16; i++) begin
      issue(vt[i].valid, vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].isel, 5'd1, 5'd2, vt[i].rw);
      #1;
      chk($sformatf("vec%0d.stall", i), 16'(stall_ex), 16'd0);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_ans, vt[i].e_bb, vt[i].e_rw, vt[i].e_mem, vt[i].e_z, vt[i].e_c);
    end

    // Back-to-back dependency forwarded from EX.
    issue(1'b1, 5'b00000, 8'h12, 8'h34, 8'h00, 1'b0, 5'd8, 5'd9, 5'd1);
    #1; chk("fwd_add.stall", 16'(stall_ex), 16'd0);
    step();
    chk_all("fwd_add", 8'h46, 8'h34, 5'd1, 3'b000, 1'b0, 1'b0);
    issue(1'b1, 5'b00001, 8'h77, 8'h55, 8'h00, 1'b0, 5'd1, 5'd1, 5'd2);
    #1; chk("fwd_sub.stall", 16'(stall_ex), 16'd0);
    step();
    chk_all("fwd_sub", 8'h00, 8'h46, 5'd2, 3'b000, 1'b1, 1'b0);

    // Load-use: one stall cycle, one bubble, then forward from memory stage.
    issue(1'b1, 5'b01001, 8'h20, 8'h00, 8'h03, 1'b1, 5'd8, 5'd9, 5'd4);
    step();
    chk_all("ld", 8'h23, 8'h00, 5'd4, 3'b101, 1'b1, 1'b0);
    issue(1'b1, 5'b00000, 8'h99, 8'h01, 8'h00, 1'b0, 5'd4, 5'd9, 5'd7);
    #1; chk("ldu.stall1", 16'(stall_ex), 16'd1);
    step();
    chk_all("ldu.bubble", 8'h00, 8'h00, 5'd0, 3'b000, 1'b1, 1'b0);
    mux_ans_dm = 8'h40; RW_dm = 5'd4;
    #1; chk("ldu.stall2", 16'(stall_ex), 16'd0);
    step();
    chk_all("ldu.add", 8'h41, 8'h01, 5'd7, 3'b000, 1'b0, 1'b0);

    // Store with data forwarded from the memory stage.
    mux_ans_dm = 8'hAB; RW_dm = 5'd3;
    issue(1'b1, 5'b01010, 8'h10, 8'h11, 8'h05, 1'b0, 5'd8, 5'd3, 5'd9);
    step();
    chk_all("st", 8'h15, 8'hAB, 5'd0, 3'b110, 1'b0, 1'b0);
    mux_ans_dm = 8'h00; RW_dm = 5'd0;

    // Multiply 0x13 * 0x0E = 0x10A.
    issue(1'b1, 5'b01011, 8'h13, 8'h0E, 8'h00, 1'b0, 5'd8, 5'd9, 5'd5);
    for (int i = 0; i < 8; i++) begin
      #1; chk($sformatf("mul.stall%0d", i), 16'(stall_ex), 16'd1);
      step();
      chk($sformatf("mul.bubble_ans%0d", i), 16'(ans_ex), 16'h00);
      chk($sformatf("mul.bubble_rw%0d", i), 16'(RW_ex), 16'd0);
    end
    #1; chk("mul.stall_final", 16'(stall_ex), 16'd0);
    step();
    chk_all("mul", 8'h0A, 8'h00, 5'd5, 3'b000, 1'b0, 1'b1);

    // Reset during MUL_BUSY at count 3 abandons the multiply.
    issue(1'b1, 5'b01011, 8'hFF, 8'hFF, 8'h00, 1'b0, 5'd8, 5'd9, 5'd6);
    step();
    step();
    step();
    step();
    #1; chk("mrst.busy_stall", 16'(stall_ex), 16'd1);
    reset = 1'b1;
    #1; chk("mrst.stall_in_reset", 16'(stall_ex), 16'd0);
    step();
    chk_all("mrst", 8'h00, 8'h00, 5'd0, 3'b000, 1'b0, 1'b0);
    reset = 1'b0;
    issue(1'b1, 5'b00000, 8'h01, 8'h01, 8'h00, 1'b0, 5'd8, 5'd9, 5'd3);
    #1; chk("post_rst.stall", 16'(stall_ex), 16'd0);
    step();
    chk_all("post_rst.add", 8'h02, 8'h01, 5'd3, 3'b000, 1'b0, 1'b0);
    issue(1'b0, 5'b11111, 8'h00, 8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("mrst.idle_rw%0d", i), 16'(RW_ex), 16'd0);
      chk($sformatf("mrst.idle_c%0d", i), 16'(flag_c), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
